spi_flash_reader: RTL

Command sequencer that sits directly upstream of the SPI byte-exchange engine and drives it to perform SPI NOR flash read transactions. It accepts a read request (24-bit address, byte count), owns chip select, issues the command and address bytes through the engine, then streams the returned data bytes out over a valid/ready port with backpressure. It is the boot/XIP fetch path between the SoC bus side and the SPI byte engine.

---
 rtl/spi_flash_reader_if.sv | 27 ++
 rtl/spi_flash_reader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader_if.sv
// Bundles the read-request port, the returned-data stream and the SPI byte-engine
// handshake of spi_flash_reader. master = requester/engine side, slave = sequencer.
interface spi_flash_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic [7:0]  data;
    logic        data_valid;
    logic        data_ready;
    logic        done;
    logic        cs_n;
    logic [7:0]  spi_so;
    logic        spi_ex;
    logic [7:0]  spi_si;
    logic        spi_busy;

    modport master (
        output req_valid, req_addr, req_len, data_ready, spi_si, spi_busy,
        input  req_ready, data, data_valid, done, cs_n, spi_so, spi_ex
    );

    modport slave (
        input  req_valid, req_addr, req_len, data_ready, spi_si, spi_busy,
        output req_ready, data, data_valid, done, cs_n, spi_so, spi_ex
    );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI NOR read sequencer: drives a byte-exchange engine through command, address and
// data phases, streaming data out with backpressure. Define SPI_FLASH_FAST_READ_EN for 0x0B + dummy byte.
module spi_flash_reader #(
    parameter int CS_GAP = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    spi_flash_reader_if.slave    if_bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR2, S_ADDR1, S_ADDR0, S_DUMMY, S_DATA, S_HOLD, S_GAP
    } state_t;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
`endif

    state_t      r_state, w_state_next;
    logic        r_cs_n, w_cs_n_next;
    logic        r_pend, w_pend_next;
    logic        r_age, w_age_next;
    logic [23:0] r_addr, w_addr_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic [7:0]  r_data, w_data_next;
    logic        r_data_valid, w_data_valid_next;
    logic        r_done, w_done_next;
    logic [7:0]  r_gap, w_gap_next;

    logic        w_xfer_state;
    logic        w_ex;
    logic        w_byte_done;
    logic [7:0]  w_so;

    assign w_xfer_state = (r_state == S_CMD)   || (r_state == S_ADDR2) ||
                          (r_state == S_ADDR1) || (r_state == S_ADDR0) ||
                          (r_state == S_DUMMY) || (r_state == S_DATA);

    // One exchange per state entry: strobe only while no byte is in flight.
    assign w_ex        = w_xfer_state && !r_pend && !r_cs_n;
    // r_age masks the first cycle after the strobe, before the engine raises busy.
    assign w_byte_done = r_pend && r_age && !if_bus.spi_busy;

    always_comb begin
        w_so = 8'hFF;
        case (r_state)
            S_CMD:   w_so = READ_CMD;
            S_ADDR2: w_so = r_addr[23:16];
            S_ADDR1: w_so = r_addr[15:8];
            S_ADDR0: w_so = r_addr[7:0];
            default: w_so = 8'hFF;
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        w_cs_n_next       = r_cs_n;
        w_pend_next       = r_pend;
        w_age_next        = r_age;
        w_addr_next       = r_addr;
        w_cnt_next        = r_cnt;
        w_data_next       = r_data;
        w_data_valid_next = r_data_valid;
        w_done_next       = 1'b0;
        w_gap_next        = r_gap;

        if (w_ex) begin
            w_pend_next = 1'b1;
            w_age_next  = 1'b0;
        end else if (r_pend) begin
            w_age_next = 1'b1;
            if (w_byte_done) begin
                w_pend_next = 1'b0;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (if_bus.req_valid) begin
                    if (if_bus.req_len != 16'd0) begin
                        w_addr_next  = if_bus.req_addr;
                        w_cnt_next   = if_bus.req_len;
                        w_cs_n_next  = 1'b0;
                        w_state_next = S_CMD;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            S_CMD:   if (w_byte_done) w_state_next = S_ADDR2;
            S_ADDR2: if (w_byte_done) w_state_next = S_ADDR1;
            S_ADDR1: if (w_byte_done) w_state_next = S_ADDR0;
`ifdef SPI_FLASH_FAST_READ_EN
            S_ADDR0: if (w_byte_done) w_state_next = S_DUMMY;
`else
            S_ADDR0: if (w_byte_done) w_state_next = S_DATA;
`endif
            S_DUMMY: if (w_byte_done) w_state_next = S_DATA;
            S_DATA: begin
                if (w_byte_done) begin
                    w_data_next       = if_bus.spi_si;
                    w_data_valid_next = 1'b1;
                    w_cnt_next        = r_cnt - 16'd1;
                    w_state_next      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (if_bus.data_ready) begin
                    w_data_valid_next = 1'b0;
                    if (r_cnt != 16'd0) begin
                        w_state_next = S_DATA;
                    end else begin
                        w_cs_n_next  = 1'b1;
                        w_gap_next   = 8'd0;
                        w_state_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == 8'(CS_GAP - 1)) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_next = r_gap + 8'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cs_n       <= 1'b1;
            r_pend       <= 1'b0;
            r_age        <= 1'b0;
            r_addr       <= 24'd0;
            r_cnt        <= 16'd0;
            r_data       <= 8'h00;
            r_data_valid <= 1'b0;
            r_done       <= 1'b0;
            r_gap        <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_cs_n       <= w_cs_n_next;
            r_pend       <= w_pend_next;
            r_age        <= w_age_next;
            r_addr       <= w_addr_next;
            r_cnt        <= w_cnt_next;
            r_data       <= w_data_next;
            r_data_valid <= w_data_valid_next;
            r_done       <= w_done_next;
            r_gap        <= w_gap_next;
        end
    end

    assign if_bus.req_ready  = (r_state == S_IDLE);
    assign if_bus.data       = r_data;
    assign if_bus.data_valid = r_data_valid;
    assign if_bus.done       = r_done;
    assign if_bus.cs_n       = r_cs_n;
    assign if_bus.spi_so     = w_so;
    assign if_bus.spi_ex     = w_ex;

endmodule
